// File: rtl/hdmi_video_timing_if.sv
// Video timing output bundle: sync, data enable, raster position and strobes.
// The timing generator drives it through the master modport; the scaler/HDMI
// transmitter side consumes it through the slave modport.
interface hdmi_video_timing_if;
  logic        running;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        line_start;
  logic        frame_start;

  modport master (
    output running, hs, vs, de, hcount, vcount, line_start, frame_start
  );

  modport slave (
    input running, hs, vs, de, hcount, vcount, line_start, frame_start
  );
endinterface

// File: rtl/hdmi_video_timing.sv
// Raster timing generator running on the HDMI pixel clock.
// Waits for the PLL lock to be stable for LOCK_WAIT clocks, then free-runs the
// horizontal/vertical counters and emits registered HS/VS/DE, coordinates and
// line/frame strobes. Any loss of lock drops back to idle immediately; the
// partial frame is abandoned and a fresh frame starts after requalification.
module hdmi_video_timing #(
  parameter int   H_ACTIVE  = 1280,
  parameter int   H_FP      = 110,
  parameter int   H_SYNC    = 40,
  parameter int   H_BP      = 220,
  parameter int   V_ACTIVE  = 720,
  parameter int   V_FP      = 5,
  parameter int   V_SYNC    = 5,
  parameter int   V_BP      = 20,
  parameter logic HS_POL    = 1'b1,
  parameter logic VS_POL    = 1'b1,
  parameter int   LOCK_WAIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  hdmi_video_timing_if.master   vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Lock counter only ever needs to reach LOCK_WAIT-1.
  localparam int LW_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [LW_W-1:0] LOCK_LAST = LW_W'(LOCK_WAIT - 1);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Decode bounds are kept 13 bits wide so a 4096 total does not wrap.
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEGIN   = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END     = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEGIN   = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END     = 13'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state_reg;
  logic [LW_W-1:0] lock_cnt_reg;
  logic [11:0]     h_reg;
  logic [11:0]     v_reg;
  logic            lock_meta_reg;
  logic            lk;

  logic [12:0]     h_ext;
  logic [12:0]     v_ext;
  logic            de_raw;
  logic            hs_active;
  logic            vs_active;

  // Two-flop synchronizer for the PLL lock, which is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta_reg <= 1'b0;
      lk            <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lk            <= lock_meta_reg;
    end
  end

  // Lock qualification and raster counters; a low lk aborts from any state.
  always_ff @(posedge clk) begin
    if (!rst_n || !lk) begin
      state_reg    <= WAIT_LOCK;
      lock_cnt_reg <= '0;
      h_reg        <= '0;
      v_reg        <= '0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          state_reg    <= STABLE;
          lock_cnt_reg <= '0;
        end
        STABLE: begin
          if (lock_cnt_reg == LOCK_LAST) begin
            state_reg <= RUN;
            h_reg     <= '0;
            v_reg     <= '0;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (h_reg == H_LAST) begin
            h_reg <= '0;
            v_reg <= (v_reg == V_LAST) ? 12'd0 : v_reg + 12'd1;
          end else begin
            h_reg <= h_reg + 12'd1;
          end
        end
        default: begin
          state_reg    <= WAIT_LOCK;
          lock_cnt_reg <= '0;
          h_reg        <= '0;
          v_reg        <= '0;
        end
      endcase
    end
  end

  assign h_ext     = {1'b0, h_reg};
  assign v_ext     = {1'b0, v_reg};
  assign de_raw    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign hs_active = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
  assign vs_active = (v_ext >= VS_BEGIN) && (v_ext < VS_END);

  // Registered output decode: describes the counter state of the previous clock.
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != RUN) begin
      vid.running     <= 1'b0;
      vid.hs          <= ~HS_POL;
      vid.vs          <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.hcount      <= '0;
      vid.vcount      <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.running     <= 1'b1;
      vid.hs          <= hs_active ? HS_POL : ~HS_POL;
      vid.vs          <= vs_active ? VS_POL : ~VS_POL;
      vid.de          <= de_raw;
      vid.hcount      <= h_reg;
      vid.vcount      <= v_reg;
      vid.line_start  <= (h_reg == 12'd0);
      vid.frame_start <= (h_reg == 12'd0) && (v_reg == 12'd0);
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: a small-raster instance checked every clock
// against a lock-history model through a scoreboard queue, a segment table of
// lock/reset patterns, and hand sequences for lock loss, inverted polarity
// and one full 720p line.
module tb_hdmi_video_timing;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int LW = 4;
  localparam int HT = HA + HF + HSY + HB;  // 14
  localparam int VT = VA + VF + VSY + VB;  // 7

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b1;

  always #5 clk = ~clk;

  hdmi_video_timing_if vid_s ();
  hdmi_video_timing_if vid_n ();
  hdmi_video_timing_if vid_hd ();

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_WAIT(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .vid(vid_s)
  );

  hdmi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(LW)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .vid(vid_n)
  );

  hdmi_video_timing #(
    .LOCK_WAIT(LW)
  ) dut_hd (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .vid(vid_hd)
  );

  typedef struct packed {
    logic        running;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        line_start;
    logic        frame_start;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   lock_run = 0;
  int   hist[4] = '{0, 0, 0, 0};

  // Expected outputs given k = consecutive high lock samples ending 3 edges ago.
  // Raster position 0 appears once k reaches LW+1.
  function automatic exp_t model(input int k);
    exp_t e;
    int p, h, v;
    e = '0;
    if (k >= LW + 1) begin
      p = k - (LW + 1);
      h = p % HT;
      v = (p / HT) % VT;
      e.running     = 1'b1;
      e.de          = (h < HA) && (v < VA);
      e.hs          = (h >= HA + HF) && (h < HA + HF + HSY);
      e.vs          = (v >= VA + VF) && (v < VA + VF + VSY);
      e.hcount      = 12'(h);
      e.vcount      = 12'(v);
      e.line_start  = (h == 0);
      e.frame_start = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  // Producer: record the lock history at each edge and queue the expectation.
  always @(posedge clk) begin
    if (!rst_n) begin
      lock_run = 0;
      hist = '{0, 0, 0, 0};
    end else begin
      lock_run = pll_locked ? lock_run + 1 : 0;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = lock_run;
    end
    sb_q.push_back(model(hist[3]));
  end

  // Consumer: compare the small-raster outputs every clock.
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    g = '{vid_s.running, vid_s.hs, vid_s.vs, vid_s.de, vid_s.hcount,
          vid_s.vcount, vid_s.line_start, vid_s.frame_start};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty t=%0t got queue size 0 required >0", $time);
    end else begin
      e = sb_q.pop_front();
      if (g !== e) begin
        n_err++;
        $display("FAIL sb t=%0t got run=%b hs=%b vs=%b de=%b h=%0d v=%0d ls=%b fs=%b required run=%b hs=%b vs=%b de=%b h=%0d v=%0d ls=%b fs=%b",
                 $time, g.running, g.hs, g.vs, g.de, g.hcount, g.vcount, g.line_start, g.frame_start,
                 e.running, e.hs, e.vs, e.de, e.hcount, e.vcount, e.line_start, e.frame_start);
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Wait until the small instance shows (hc,vc) while running, bounded.
  task automatic wait_pos(input int hc, input int vc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      if (vid_s.running && vid_s.hcount == 12'(hc) && vid_s.vcount == 12'(vc)) ok = 1'b1;
    end
    check(name, int'(ok), 1);
  endtask

  typedef struct {
    logic rst_n;
    logic locked;
    int   cycles;
    logic exp_running;
    int   exp_fs;
    int   exp_first;
  } seg_t;

  seg_t segs[7];

  initial begin
    int fs, first, n, de_cnt, hs_cnt, vs_cnt;
    bit found;

    // rst, lock, cycles, running at end, frame_starts seen, first fs index
    segs[0] = '{1'b0, 1'b1,   5, 1'b0, 0, -1};  // reset with lock high
    segs[1] = '{1'b1, 1'b1, 200, 1'b1, 2,  7};  // startup: LW+3 latency, 98/frame
    segs[2] = '{1'b1, 1'b0,  10, 1'b0, 0, -1};  // lock loss near frame end
    segs[3] = '{1'b1, 1'b1,   2, 1'b0, 0, -1};  // short glitch high
    segs[4] = '{1'b1, 1'b0,   3, 1'b0, 0, -1};
    segs[5] = '{1'b1, 1'b1,  20, 1'b1, 1,  7};  // no early start after glitch
    segs[6] = '{1'b0, 1'b1,   3, 1'b0, 0, -1};  // reset overrides lock

    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      rst_n = segs[s].rst_n;
      pll_locked = segs[s].locked;
      fs = 0;
      first = -1;
      for (int c = 0; c < segs[s].cycles; c++) begin
        @(posedge clk); #1;
        if (vid_s.frame_start) begin
          fs++;
          if (first < 0) first = c;
        end
      end
      check($sformatf("seg%0d_running", s), int'(vid_s.running), int'(segs[s].exp_running));
      check($sformatf("seg%0d_fs_count", s), fs, segs[s].exp_fs);
      check($sformatf("seg%0d_fs_first", s), first, segs[s].exp_first);
      if (s == 0) begin
        check("reset_neg_hs", int'(vid_n.hs), 1);
        check("reset_neg_vs", int'(vid_n.vs), 1);
      end
    end

    // Lock loss mid-line at hcount 5, vcount 2, then requalification.
    @(negedge clk);
    rst_n = 1'b1;
    wait_pos(5, 2, "reach_h5_v2");
    @(negedge clk);
    pll_locked = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(posedge clk); #1;
      if (!vid_s.running) begin
        found = 1'b1;
        n = i - 1;
      end
    end
    check("loss_latency", found ? n : -1, 3);
    check("loss_de", int'(vid_s.de), 0);
    check("loss_hs", int'(vid_s.hs), 0);
    check("loss_vs", int'(vid_s.vs), 0);
    @(negedge clk);
    pll_locked = 1'b1;
    n = -1;
    for (int i = 0; i < 50 && n < 0; i++) begin
      @(posedge clk); #1;
      if (vid_s.frame_start) n = i;
    end
    check("relock_latency", n, LW + 3);
    check("relock_hcount", int'(vid_s.hcount), 0);
    check("relock_vcount", int'(vid_s.vcount), 0);
    check("relock_de", int'(vid_s.de), 1);

    // Inverted polarity instance runs in lockstep with the small instance.
    wait_pos(3, 0, "reach_h3_v0");
    check("neg_hs_idle", int'(vid_n.hs), 1);
    check("neg_vs_idle", int'(vid_n.vs), 1);
    wait_pos(10, 0, "reach_h10_v0");
    check("neg_hs_active", int'(vid_n.hs), 0);
    wait_pos(0, 5, "reach_h0_v5");
    check("neg_vs_active", int'(vid_n.vs), 0);
    check("neg_running", int'(vid_n.running), 1);

    // Default 720p raster: one complete line.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (vid_hd.frame_start) found = 1'b1;
    end
    check("hd_frame_start", int'(found), 1);
    n = 0;
    de_cnt = 0;
    hs_cnt = 0;
    vs_cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (vid_hd.de) de_cnt++;
      if (vid_hd.hs) hs_cnt++;
      if (vid_hd.vs) vs_cnt++;
      @(posedge clk); #1;
      n++;
      if (vid_hd.line_start) found = 1'b1;
    end
    check("hd_line_len", n, 1650);
    check("hd_de_count", de_cnt, 1280);
    check("hd_hs_width", hs_cnt, 40);
    check("hd_vs_line0", vs_cnt, 0);
    check("hd_vcount_line1", int'(vid_hd.vcount), 1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Raster timing generator clocked by the HDMI pixel clock output of the HDMI PLL; 74.25 MHz for the default 1280x720@60 mode.
- Qualifies the PLL `locked` signal, then free-runs horizontal and vertical counters.
- Produces registered HS/VS/DE plus pixel coordinates and frame/line strobes for the scaler/HDMI transmitter path.
- Holds all outputs idle whenever the PLL is not locked.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, HS active level (1 = active high)
- VS_POL, 1, VS active level
- LOCK_WAIT, 1024, clocks `locked` must stay high before timing starts (≥1)

Ports:
- clk  in  1  pixel clock (PLL outclk_0)
- rst_n  in  1  synchronous active-low reset
- pll_locked  in  1  PLL locked; asynchronous to clk
- running  out  1  high while in RUN
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  data enable (active video)
- hcount  out  12  horizontal position of current output cycle
- vcount  out  12  vertical position of current output cycle
- line_start  out  1  one-clock pulse, hcount==0
- frame_start  out  1  one-clock pulse, hcount==0 and vcount==0

Behaviour:
- Reset (rst_n low at a clk edge): state WAIT_LOCK, sync flops 0, lock counter 0, h/v counters 0. Outputs: running=0, hs=~HS_POL, vs=~VS_POL, de=0, hcount=0, vcount=0, line_start=0, frame_start=0.
- Derived sizes: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 1650); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 750). Both must be ≤4096; counters are 12 bits.
- Lock sync: pll_locked passes through 2 flops to give lk. lk goes high 2 clocks after pll_locked rises.
- WAIT_LOCK: lock counter=0. When lk=1, go to STABLE.
- STABLE: lock counter increments each clock while lk=1. When it equals LOCK_WAIT-1, go to RUN with h=0, v=0.
- RUN: h increments each clock. At h==H_TOTAL-1, h wraps to 0 and v increments. At v==V_TOTAL-1 with h==H_TOTAL-1, v wraps to 0.
- Loss of lock: lk=0 in any state takes effect at the next clock. State → WAIT_LOCK; lock, h and v counters cleared; outputs return to reset values one clock later. A partial frame is simply abandoned; there is no resync to a frame boundary.
- Output decode, registered: all outputs are 1 clock after the counter state they describe, so all outputs are mutually aligned.
  - de = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hs = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vs = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (whole lines, edges at h==0), else ~VS_POL
  - hcount=h, vcount=v
  - line_start = (h==0)
  - frame_start = (h==0 && v==0)
  - running = 1 for every output cycle derived from RUN
- Latency: the first frame_start occurs exactly LOCK_WAIT+3 clocks after the clock edge where pll_locked is first sampled high (with pll_locked stable from then on). Breakdown: 2 sync + LOCK_WAIT qualify + 1 output register.
- Glitch below LOCK_WAIT: if lk drops during STABLE, the count restarts from 0 on the next lk rise.
- rst_n has priority over all lock events.

Test Plan:
- Reset: hold rst_n=0 for 5 clocks with pll_locked=1 → all outputs at reset values, running=0, hs=vs=0 (default pol).
- Startup latency, small mode (H 8/2/2/2, V 4/1/1/1, LOCK_WAIT=4): raise pll_locked at edge T → frame_start and running first high at T+7, de=1 with hcount=0, vcount=0.
- Raster check, small mode: per line 14 clocks, de high for 8, hs high at hcount 10–11. Per frame 7 lines, vs high for exactly vcount 5 (14 clocks). frame_start every 98 clocks.
- Default 720p: measure 1650 clocks/line, 750 lines/frame, 921600 de-clocks/frame, hs width 40, vs width 5×1650.
- Lock loss mid-line, small mode: drop pll_locked at hcount 5, vcount 2 → running/de fall 3 clocks later, hs=vs=0. Re-raise → frame_start again exactly LOCK_WAIT+3 clocks later, at hcount=vcount=0.
- Lock glitch: pll_locked high for 2 clocks (sync'd) then low then high, LOCK_WAIT=4 → no early start; frame_start exactly 7 clocks after the final rise. HS_POL=0 → hs idle 1, active 0.
